// File: rtl/decode_cycle.sv
// decode_cycle: RV32I ID stage. Holds the 32x32 register file, main/ALU control
// decode, the immediate extender and the ID/EX pipeline register.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN adds the registered IllegalE output.
module decode_cycle #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  o_p_waitrequest,
    input  logic                  FlushE,
    input  logic [31:0]           InstrD,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic                  RegWriteW,
    input  logic [4:0]            RDW,
    input  logic [DATA_WIDTH-1:0] ResultW,
    output logic                  RegWriteE,
    output logic [1:0]            ResultSrcE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic                  JalrE,
    output logic                  ALUSrcE,
    output logic [2:0]            ALUControlE,
    output logic [2:0]            Funct3E,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                  IllegalE,
`endif
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [4:0]            RS1E,
    output logic [4:0]            RS2E,
    output logic [4:0]            RDE,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [DATA_WIDTH-1:0] PCPlus4E
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluXor = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;
    localparam logic [2:0] AluSll = 3'b110;
    localparam logic [2:0] AluSrl = 3'b111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];

    // Shared R/I ALU mapping; sltu has no ALU code of its own and shares slt,
    // sra shares srl.
    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_op = sub ? AluSub : AluAdd;
            3'b001:  alu_op = AluSll;
            3'b010:  alu_op = AluSlt;
            3'b011:  alu_op = AluSlt;
            3'b100:  alu_op = AluXor;
            3'b101:  alu_op = AluSrl;
            3'b110:  alu_op = AluOr;
            default: alu_op = AluAnd;
        endcase
    endfunction

    // ---------------------------------------------------------------- register file
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    // Write port: cleared on reset, x0 never written; independent of stall/flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (RegWriteW && (RDW != 5'd0)) begin
            regs[RDW] <= ResultW;
        end
    end

    // Read ports with write-through bypass so a same-cycle writeback is seen.
    always_comb begin
        rd1 = regs[rs1];
        rd2 = regs[rs2];
        if (rs1 == 5'd0) begin
            rd1 = '0;
        end else if (RegWriteW && (RDW == rs1)) begin
            rd1 = ResultW;
        end
        if (rs2 == 5'd0) begin
            rd2 = '0;
        end else if (RegWriteW && (RDW == rs2)) begin
            rd2 = ResultW;
        end
    end

    // ---------------------------------------------------------------- immediates
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;
    logic [31:0] imm_shamt;

    assign imm_i     = {{20{InstrD[31]}}, InstrD[31:20]};
    assign imm_s     = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    assign imm_b     = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                        InstrD[11:8], 1'b0};
    assign imm_j     = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                        InstrD[30:21], 1'b0};
    assign imm_u     = {InstrD[31:12], 12'b0};
    // Shift immediates carry only the shamt so srai's funct7 bit does not leak in.
    assign imm_shamt = {27'b0, InstrD[24:20]};

    // ---------------------------------------------------------------- control decode
    logic        dec_reg_write;
    logic [1:0]  dec_result_src;
    logic        dec_mem_write;
    logic        dec_jump;
    logic        dec_branch;
    logic        dec_jalr;
    logic        dec_alu_src;
    logic [2:0]  dec_alu_ctrl;
    logic [2:0]  dec_funct3;
    logic [31:0] dec_imm;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic dec_illegal;

    // Illegal detection; the opcode compare already covers InstrD[1:0] != 2'b11.
    always_comb begin
        dec_illegal = 1'b0;
        case (opcode)
            OpR:     dec_illegal = (InstrD[31:25] != 7'b0000000) &&
                                   (InstrD[31:25] != 7'b0100000);
            OpImm, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpLui: dec_illegal = 1'b0;
            default: dec_illegal = 1'b1;
        endcase
    end
`endif

    // Main decode by opcode; anything unrecognised stays an all-zero NOP.
    always_comb begin
        dec_reg_write  = 1'b0;
        dec_result_src = 2'b00;
        dec_mem_write  = 1'b0;
        dec_jump       = 1'b0;
        dec_branch     = 1'b0;
        dec_jalr       = 1'b0;
        dec_alu_src    = 1'b0;
        dec_alu_ctrl   = AluAdd;
        dec_funct3     = 3'b000;
        dec_imm        = '0;
        case (opcode)
            OpR: begin
                dec_reg_write = 1'b1;
                dec_alu_ctrl  = alu_op(funct3, InstrD[30]);
                dec_funct3    = funct3;
            end
            OpImm: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_ctrl  = alu_op(funct3, 1'b0);
                dec_funct3    = funct3;
                dec_imm       = (funct3 == 3'b001 || funct3 == 3'b101) ? imm_shamt : imm_i;
            end
            OpLoad: begin
                dec_reg_write  = 1'b1;
                dec_result_src = 2'b01;
                dec_alu_src    = 1'b1;
                dec_funct3     = funct3;
                dec_imm        = imm_i;
            end
            OpStore: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_funct3    = funct3;
                dec_imm       = imm_s;
            end
            OpBranch: begin
                dec_branch   = 1'b1;
                dec_alu_ctrl = AluSub;
                dec_funct3   = funct3;
                dec_imm      = imm_b;
            end
            OpJal: begin
                dec_reg_write  = 1'b1;
                dec_result_src = 2'b10;
                dec_jump       = 1'b1;
                dec_funct3     = funct3;
                dec_imm        = imm_j;
            end
            OpJalr: begin
                dec_reg_write  = 1'b1;
                dec_result_src = 2'b10;
                dec_jump       = 1'b1;
                dec_jalr       = 1'b1;
                dec_alu_src    = 1'b1;
                dec_funct3     = funct3;
                dec_imm        = imm_i;
            end
            OpLui: begin
                dec_reg_write  = 1'b1;
                dec_result_src = 2'b11;
                dec_alu_src    = 1'b1;
                dec_funct3     = funct3;
                dec_imm        = imm_u;
            end
            default: ;
        endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (dec_illegal) begin
            dec_reg_write  = 1'b0;
            dec_result_src = 2'b00;
            dec_mem_write  = 1'b0;
            dec_jump       = 1'b0;
            dec_branch     = 1'b0;
            dec_jalr       = 1'b0;
            dec_alu_src    = 1'b0;
            dec_alu_ctrl   = AluAdd;
            dec_funct3     = 3'b000;
        end
`endif
    end

    // ---------------------------------------------------------------- ID/EX register
    // Priority: reset, then stall (hold), then flush (bubble controls), then load.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            JalrE       <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUControlE <= 3'b000;
            Funct3E     <= 3'b000;
`ifdef DECODE_ILLEGAL_TRAP_EN
            IllegalE    <= 1'b0;
`endif
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            RS1E        <= 5'd0;
            RS2E        <= 5'd0;
            RDE         <= 5'd0;
            PCE         <= '0;
            PCPlus4E    <= '0;
        end else if (!o_p_waitrequest) begin
            RD1E     <= rd1;
            RD2E     <= rd2;
            ImmExtE  <= dec_imm;
            RS1E     <= rs1;
            RS2E     <= rs2;
            RDE      <= InstrD[11:7];
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            if (FlushE) begin
                RegWriteE   <= 1'b0;
                ResultSrcE  <= 2'b00;
                MemWriteE   <= 1'b0;
                JumpE       <= 1'b0;
                BranchE     <= 1'b0;
                JalrE       <= 1'b0;
                ALUSrcE     <= 1'b0;
                ALUControlE <= 3'b000;
                Funct3E     <= 3'b000;
`ifdef DECODE_ILLEGAL_TRAP_EN
                IllegalE    <= 1'b0;
`endif
            end else begin
                RegWriteE   <= dec_reg_write;
                ResultSrcE  <= dec_result_src;
                MemWriteE   <= dec_mem_write;
                JumpE       <= dec_jump;
                BranchE     <= dec_branch;
                JalrE       <= dec_jalr;
                ALUSrcE     <= dec_alu_src;
                ALUControlE <= dec_alu_ctrl;
                Funct3E     <= dec_funct3;
`ifdef DECODE_ILLEGAL_TRAP_EN
                IllegalE    <= dec_illegal;
`endif
            end
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed, table-driven bench for the decode_cycle ID stage.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        o_p_waitrequest;
    logic        FlushE;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic        JalrE;
    logic        ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [2:0]  Funct3E;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        IllegalE;
`endif
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [4:0]  RS1E;
    logic [4:0]  RS2E;
    logic [4:0]  RDE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;

    decode_cycle dut (
        .clk             (clk),
        .rst             (rst),
        .o_p_waitrequest (o_p_waitrequest),
        .FlushE          (FlushE),
        .InstrD          (InstrD),
        .PCD             (PCD),
        .PCPlus4D        (PCPlus4D),
        .RegWriteW       (RegWriteW),
        .RDW             (RDW),
        .ResultW         (ResultW),
        .RegWriteE       (RegWriteE),
        .ResultSrcE      (ResultSrcE),
        .MemWriteE       (MemWriteE),
        .JumpE           (JumpE),
        .BranchE         (BranchE),
        .JalrE           (JalrE),
        .ALUSrcE         (ALUSrcE),
        .ALUControlE     (ALUControlE),
        .Funct3E         (Funct3E),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .IllegalE        (IllegalE),
`endif
        .RD1E            (RD1E),
        .RD2E            (RD2E),
        .ImmExtE         (ImmExtE),
        .RS1E            (RS1E),
        .RS2E            (RS2E),
        .RDE             (RDE),
        .PCE             (PCE),
        .PCPlus4E        (PCPlus4E)
    );

    always #5 clk = ~clk;

    // Packed views of the E outputs.
    logic [13:0]  ctrl_act;
    logic [255:0] all_out;
    assign ctrl_act = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE,
                       ALUControlE, Funct3E};
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign all_out = {66'b0, IllegalE, ctrl_act, RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE,
                      PCE, PCPlus4E};
`else
    assign all_out = {67'b0, ctrl_act, RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE, PCE, PCPlus4E};
`endif

    function automatic logic [13:0] ctl(input logic rw, input logic [1:0] rs, input logic mw,
                                        input logic j, input logic b, input logic jr,
                                        input logic as, input logic [2:0] alu,
                                        input logic [2:0] f3);
        ctl = {rw, rs, mw, j, b, jr, as, alu, f3};
    endfunction

    function automatic logic [31:0] add_x0(input logic [4:0] n);
        add_x0 = {7'b0, n, n, 3'b000, 5'd0, 7'b0110011};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [13:0] ctrl;
        logic        chk_imm;
        logic [31:0] imm;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [18];
    logic [13:0] addi_ctrl;

    initial begin
        // x5=DEADBEEF, x7=0x10, x8=3, all others 0 when the table runs.
        vecs[0]  = '{32'hFE000CE3, 32'h100, ctl(0, 2'b00, 0, 0, 1, 0, 0, 3'b001, 3'b000), 1'b1,
                     32'hFFFFFFF8, 32'h0, 32'h0};
        vecs[1]  = '{32'hABCDE0B7, 32'h104, ctl(1, 2'b11, 0, 0, 0, 0, 1, 3'b000, 3'b110), 1'b1,
                     32'hABCDE000, 32'h0, 32'h0};
        vecs[2]  = '{32'hFFF38093, 32'h108, ctl(1, 2'b00, 0, 0, 0, 0, 1, 3'b000, 3'b000), 1'b1,
                     32'hFFFFFFFF, 32'h10, 32'h0};
        vecs[3]  = '{32'h408384B3, 32'h10C, ctl(1, 2'b00, 0, 0, 0, 0, 0, 3'b001, 3'b000), 1'b0,
                     32'h0, 32'h10, 32'h3};
        vecs[4]  = '{32'h0083A623, 32'h110, ctl(0, 2'b00, 1, 0, 0, 0, 1, 3'b000, 3'b010), 1'b1,
                     32'hC, 32'h10, 32'h3};
        vecs[5]  = '{32'hFFC3A503, 32'h114, ctl(1, 2'b01, 0, 0, 0, 0, 1, 3'b000, 3'b010), 1'b1,
                     32'hFFFFFFFC, 32'h10, 32'h0};
        vecs[6]  = '{32'hFFDFF06F, 32'h118, ctl(1, 2'b10, 0, 1, 0, 0, 0, 3'b000, 3'b111), 1'b1,
                     32'hFFFFFFFC, 32'h0, 32'h0};
        vecs[7]  = '{32'h001000EF, 32'h11C, ctl(1, 2'b10, 0, 1, 0, 0, 0, 3'b000, 3'b000), 1'b1,
                     32'h800, 32'h0, 32'h0};
        vecs[8]  = '{32'h008380E7, 32'h120, ctl(1, 2'b10, 0, 1, 0, 1, 1, 3'b000, 3'b000), 1'b1,
                     32'h8, 32'h10, 32'h3};
        vecs[9]  = '{32'h00341593, 32'h124, ctl(1, 2'b00, 0, 0, 0, 0, 1, 3'b110, 3'b001), 1'b1,
                     32'h3, 32'h3, 32'h0};
        vecs[10] = '{32'h4042D613, 32'h128, ctl(1, 2'b00, 0, 0, 0, 0, 1, 3'b111, 3'b101), 1'b0,
                     32'h0, 32'hDEADBEEF, 32'h0};
        vecs[11] = '{32'h0083C6B3, 32'h12C, ctl(1, 2'b00, 0, 0, 0, 0, 0, 3'b100, 3'b100), 1'b0,
                     32'h0, 32'h10, 32'h3};
        vecs[12] = '{32'h0083F733, 32'h130, ctl(1, 2'b00, 0, 0, 0, 0, 0, 3'b010, 3'b111), 1'b0,
                     32'h0, 32'h10, 32'h3};
        vecs[13] = '{32'h0083E7B3, 32'h134, ctl(1, 2'b00, 0, 0, 0, 0, 0, 3'b011, 3'b110), 1'b0,
                     32'h0, 32'h10, 32'h3};
        vecs[14] = '{32'h0083A833, 32'h138, ctl(1, 2'b00, 0, 0, 0, 0, 0, 3'b101, 3'b010), 1'b0,
                     32'h0, 32'h10, 32'h3};
        vecs[15] = '{32'h008398B3, 32'h13C, ctl(1, 2'b00, 0, 0, 0, 0, 0, 3'b110, 3'b001), 1'b0,
                     32'h0, 32'h10, 32'h3};
        vecs[16] = '{32'h00000000, 32'h140, 14'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[17] = '{32'h0083A87F, 32'h144, 14'b0, 1'b0, 32'h0, 32'h10, 32'h3};

        // Reset has priority over a valid instruction and a pending writeback.
        rst             = 1'b1;
        o_p_waitrequest = 1'b0;
        FlushE          = 1'b0;
        InstrD          = 32'h00500093;
        PCD             = 32'h40;
        PCPlus4D        = 32'h44;
        RegWriteW       = 1'b1;
        RDW             = 5'd3;
        ResultW         = 32'h77;
        tick();
        check("reset edge1 outputs", all_out, 256'h0);
        tick();
        check("reset edge2 outputs", all_out, 256'h0);

        // Every register reads back zero after reset.
        rst       = 1'b0;
        RegWriteW = 1'b0;
        for (int n = 1; n < 32; n++) begin
            InstrD = add_x0(5'(n));
            tick();
            check($sformatf("reset x%0d rd1", n), RD1E, 32'h0);
            check($sformatf("reset x%0d rd2", n), RD2E, 32'h0);
        end

        // Write-through bypass.
        RegWriteW = 1'b1;
        RDW       = 5'd5;
        ResultW   = 32'hDEADBEEF;
        InstrD    = 32'h00528333;
        tick();
        check("bypass rd1", RD1E, 32'hDEADBEEF);
        check("bypass rd2", RD2E, 32'hDEADBEEF);
        check("bypass rde", RDE, 5'd6);
        check("bypass ctrl", ctrl_act, ctl(1, 2'b00, 0, 0, 0, 0, 0, 3'b000, 3'b000));

        // Preload x7 and x8; InstrD=0 must decode as a NOP.
        RDW     = 5'd7;
        ResultW = 32'h10;
        InstrD  = 32'h0;
        tick();
        check("zero instr nop ctrl", ctrl_act, 14'b0);
        RDW     = 5'd8;
        ResultW = 32'h3;
        tick();

        // x0 stays zero, both via bypass and after the write edge.
        RDW     = 5'd0;
        ResultW = 32'h1234;
        InstrD  = 32'h00000033;
        tick();
        check("x0 bypass rd1", RD1E, 32'h0);
        RegWriteW = 1'b0;
        tick();
        check("x0 after write rd1", RD1E, 32'h0);
        check("x0 after write rd2", RD2E, 32'h0);

        // Table of single-cycle decodes.
        for (int i = 0; i < 18; i++) begin
            InstrD   = vecs[i].instr;
            PCD      = vecs[i].pc;
            PCPlus4D = vecs[i].pc + 32'h4;
            tick();
            check($sformatf("v%0d ctrl", i), ctrl_act, vecs[i].ctrl);
            if (vecs[i].chk_imm) check($sformatf("v%0d imm", i), ImmExtE, vecs[i].imm);
            check($sformatf("v%0d rd1", i), RD1E, vecs[i].rd1);
            check($sformatf("v%0d rd2", i), RD2E, vecs[i].rd2);
            check($sformatf("v%0d rs", i), {RS1E, RS2E}, {vecs[i].instr[19:15],
                                                         vecs[i].instr[24:20]});
            check($sformatf("v%0d rde", i), RDE, vecs[i].instr[11:7]);
            check($sformatf("v%0d pce", i), PCE, vecs[i].pc);
            check($sformatf("v%0d pc4e", i), PCPlus4E, vecs[i].pc + 32'h4);
        end

        // Stall with flush held: everything frozen; regfile write still lands.
        addi_ctrl = ctl(1, 2'b00, 0, 0, 0, 0, 1, 3'b000, 3'b000);
        InstrD    = 32'hFFF38093;
        PCD       = 32'h200;
        PCPlus4D  = 32'h204;
        tick();
        check("pre-stall ctrl", ctrl_act, addi_ctrl);
        o_p_waitrequest = 1'b1;
        FlushE          = 1'b1;
        InstrD          = 32'h0083A623;
        PCD             = 32'h300;
        PCPlus4D        = 32'h304;
        RegWriteW       = 1'b1;
        RDW             = 5'd7;
        ResultW         = 32'h55;
        for (int c = 0; c < 3; c++) begin
            tick();
            RegWriteW = 1'b0;
            check($sformatf("stall%0d ctrl", c), ctrl_act, addi_ctrl);
            check($sformatf("stall%0d rd1", c), RD1E, 32'h10);
            check($sformatf("stall%0d imm", c), ImmExtE, 32'hFFFFFFFF);
            check($sformatf("stall%0d pce", c), PCE, 32'h200);
        end
        o_p_waitrequest = 1'b0;
        tick();
        check("flush after stall ctrl", ctrl_act, 14'b0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("flush after stall illegal", IllegalE, 1'b0);
`endif
        FlushE   = 1'b0;
        InstrD   = 32'hFFF38093;
        PCD      = 32'h308;
        PCPlus4D = 32'h30C;
        tick();
        check("write during stall rd1", RD1E, 32'h55);
        check("post flush ctrl", ctrl_act, addi_ctrl);

        // Reset while stalled clears outputs and the register file.
        InstrD = 32'h00528333;
        tick();
        check("pre-reset rd1", RD1E, 32'hDEADBEEF);
        o_p_waitrequest = 1'b1;
        rst             = 1'b1;
        tick();
        check("reset over stall outputs", all_out, 256'h0);
        rst             = 1'b0;
        o_p_waitrequest = 1'b0;
        tick();
        check("regfile cleared x5 rd1", RD1E, 32'h0);
        InstrD = 32'h00838033;
        tick();
        check("regfile cleared x7 rd1", RD1E, 32'h0);
        check("regfile cleared x8 rd2", RD2E, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- ID stage of the 5-stage RV32I pipeline; sits directly downstream of the fetch stage and consumes its InstrD/PCD/PCPlus4D pipeline register.
- Contains the 32x32 register file, main/ALU control decode, immediate extender and the ID/EX pipeline register.
- Writeback port feeds the register file; outputs drive the execute stage.
- Shares the fetch stage's memory stall (o_p_waitrequest) and takes a flush from execute on a taken branch or jump.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- NUM_REGS, 32, register count; x0 is hardwired to zero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- o_p_waitrequest  in  1  memory stall; 1 freezes the ID/EX register.
- FlushE  in  1  taken branch/jump in EX; bubbles the ID/EX register.
- InstrD  in  32  instruction from fetch.
- PCD  in  32  PC of InstrD.
- PCPlus4D  in  32  PCD+4.
- RegWriteW  in  1  writeback enable.
- RDW  in  5  writeback destination.
- ResultW  in  32  writeback data.
- RegWriteE  out  1  control to EX.
- ResultSrcE  out  2  00 ALU, 01 load data, 10 PC+4, 11 immediate (LUI).
- MemWriteE  out  1  store.
- JumpE  out  1  JAL/JALR.
- BranchE  out  1  conditional branch.
- JalrE  out  1  target is RD1+imm rather than PC+imm.
- ALUSrcE  out  1  0 = RD2, 1 = immediate.
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- Funct3E  out  3  branch/load/store sub-type.
- RD1E, RD2E  out  32  register operands.
- ImmExtE  out  32  sign-extended immediate.
- RS1E, RS2E, RDE  out  5  register indices, for hazard forwarding.
- PCE, PCPlus4E  out  32  passed-through PC values.

Behaviour:
- Reset:
  - All ID/EX outputs are 0 on the first rising edge with rst=1.
  - All register-file entries are cleared to 0.
  - Reset has priority over every other input.
- Register file:
  - Two combinational read ports, addressed by InstrD[19:15] and InstrD[24:20].
  - One write port, updated on a rising edge when RegWriteW=1 and RDW!=0. The write is independent of stall and flush.
  - Writes to x0 are ignored; x0 always reads 0.
  - Write-through bypass: if RegWriteW=1, RDW!=0 and RDW equals a read index in the same cycle, that read returns ResultW.
- Decode, by opcode:
  - R (0110011): RegWrite, ALU from funct3/funct7. funct7[5] selects sub vs add.
  - I-ALU (0010011): ALUSrc=1. slli/srli use imm[4:0]. srai is treated as srl.
  - Load (0000011): ResultSrc=01, add.
  - Store (0100011): MemWrite, S-imm, add.
  - Branch (1100011): BranchE, B-imm, sub.
  - JAL (1101111): JumpE, J-imm, ResultSrc=10.
  - JALR (1100111): JumpE, JalrE, I-imm, ResultSrc=10.
  - LUI (0110111): U-imm, ResultSrc=11.
  - Any other opcode: all control outputs 0 (NOP).
- Immediates: I, S, B, J sign-extended from bit 31; B and J have LSB=0. U = {instr[31:12], 12'b0}.
- ID/EX register update on each rising edge, in priority order:
  - rst: all outputs 0.
  - else o_p_waitrequest=1: hold every output.
  - else FlushE=1: all control outputs 0; data fields may update.
  - else: load decoded values.
- Stall and flush together: stall wins. FlushE stays asserted because the EX stage is frozen, so the flush takes effect on the first unstalled edge.
- Latency: InstrD to E outputs is 1 cycle.
- An InstrD of 0 (fetch reset value) decodes as NOP.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- When defined:
  - Add output IllegalE (1 bit), registered with the same reset/stall/flush rules as the other E outputs.
  - IllegalE=1 for an unknown opcode, or an R-type with funct7 other than 0000000/0100000, or InstrD[1:0]!=11.
  - Control outputs are still forced to 0 for an illegal instruction.
- When undefined: the port is absent; unknown encodings silently become NOPs.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then read x1..x31 via InstrD = add x0,xN,xN -> RD1E=RD2E=0; all control outputs 0.
- Write-through bypass: RegWriteW=1, RDW=5, ResultW=0xDEADBEEF, same cycle InstrD = add x6,x5,x5 -> next cycle RD1E=RD2E=0xDEADBEEF, RDE=6, ALUControlE=000, RegWriteE=1.
- x0 protection: RegWriteW=1, RDW=0, ResultW=0x1234 -> reading x0 returns 0.
- Immediate decode:
  - beq at PCD=0x100 with offset -8 (InstrD=0xFE000CE3) -> ImmExtE=0xFFFFFFF8, BranchE=1, ALUControlE=001, PCE=0x100.
  - lui x1,0xABCDE -> ImmExtE=0xABCDE000, ResultSrcE=11.
- Stall then flush:
  - Load a valid addi, then assert o_p_waitrequest=1 for 3 cycles with FlushE=1 -> outputs unchanged throughout.
  - Drop waitrequest -> next edge RegWriteE=MemWriteE=BranchE=JumpE=0.
- Reset mid-operation: rst=1 while o_p_waitrequest=1 with valid E contents -> next edge all outputs 0 and register file cleared.
